// File: rtl/rotation_aligner_if.sv
// Handshake and data bundle between a requester and the rotation aligner.
interface rotation_aligner_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHIFT_W = 3
);
    logic               start;
    logic [WIDTH-1:0]   in;
    logic [WIDTH-1:0]   pattern;
    logic               shift_l_r;
    logic               busy;
    logic               done;
    logic               match;
    logic [SHIFT_W-1:0] shift_by;
    logic [WIDTH-1:0]   out;

    // Requester side: issues searches and observes results.
    modport master (
        output start, in, pattern, shift_l_r,
        input  busy, done, match, shift_by, out
    );

    // Aligner side: accepts searches and reports results.
    modport slave (
        input  start, in, pattern, shift_l_r,
        output busy, done, match, shift_by, out
    );
endinterface

// File: rtl/rotation_aligner.sv
// Searches one bit position per clock for the smallest rotation that turns
// the captured word back into the reference pattern.
module rotation_aligner #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHIFT_W = 3
) (
    input  logic                 CK,
    input  logic                 RS,
    rotation_aligner_if.slave    bus
);
    localparam int unsigned LAST = WIDTH - 1;

    typedef enum logic [0:0] {IDLE, SEARCH} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   in_copy_q, in_copy_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic               dir_q, dir_d;
    logic [SHIFT_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               match_q, match_d;
    logic [SHIFT_W-1:0] shift_by_q, shift_by_d;
    logic [WIDTH-1:0]   out_q, out_d;

    logic               hit;
    logic               last;

    assign hit  = (q_q == pat_q);
    assign last = (cnt_q == SHIFT_W'(LAST));

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CK or posedge RS) begin
        if (RS) begin
            state_q    <= IDLE;
            q_q        <= '0;
            in_copy_q  <= '0;
            pat_q      <= '0;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            match_q    <= 1'b0;
            shift_by_q <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            in_copy_q  <= in_copy_d;
            pat_q      <= pat_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            match_q    <= match_d;
            shift_by_q <= shift_by_d;
            out_q      <= out_d;
        end
    end

    // Next-state: accept start only in IDLE, leave SEARCH on hit or exhaustion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = SEARCH;
            SEARCH:  if (hit || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and result updates for the current state.
    always_comb begin
        q_d        = q_q;
        in_copy_d  = in_copy_q;
        pat_d      = pat_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        match_d    = match_q;
        shift_by_d = shift_by_q;
        out_d      = out_q;
        busy_d     = (state_d == SEARCH);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d       = bus.in;
                    in_copy_d = bus.in;
                    pat_d     = bus.pattern;
                    dir_d     = bus.shift_l_r;
                    cnt_d     = '0;
                end
            end
            SEARCH: begin
                if (hit) begin
                    match_d    = 1'b1;
                    shift_by_d = cnt_q;
                    out_d      = q_q;
                    done_d     = 1'b1;
                end else if (last) begin
                    match_d    = 1'b0;
                    shift_by_d = '0;
                    out_d      = in_copy_q;
                    done_d     = 1'b1;
                end else begin
                    // Undo the encoder: rotate opposite to its direction.
                    if (dir_q) q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    else       q_d = {q_q[0], q_q[WIDTH-1:1]};
                    cnt_d = cnt_q + SHIFT_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.match    = match_q;
    assign bus.shift_by = shift_by_q;
    assign bus.out      = out_q;
endmodule

// File: doc/rotation_aligner.md
# rotation_aligner

Multi-cycle word aligner that undoes the rotation applied by the team's 8-bit rotate/load shifter. It takes a rotated word and a known reference pattern. It then searches one bit position per clock for the smallest rotation amount `k` that restores the pattern, and reports `k`, a match flag and the realigned word. It sits on the receive side of the same datapath, downstream of the rotate stage.

## Interface
- `WIDTH`, default 8: data word width; must equal 2**`SHIFT_W`.
- `SHIFT_W`, default 3: width of the reported rotation amount.

- `CK`  input  1  clock, rising-edge.
- `RS`  input  1  reset, asynchronous, active-high.
- `start`  input  1  request a search; sampled on `CK` only while idle.
- `in`  input  WIDTH  rotated word; captured on an accepted `start`.
- `pattern`  input  WIDTH  reference word; captured on an accepted `start`.
- `shift_l_r`  input  1  direction the encoder used (0 = left rotate, 1 = right rotate); captured on an accepted `start`.
- `busy`  output  1  high while a search is in progress.
- `done`  output  1  one-cycle pulse when a search completes.
- `match`  output  1  result valid with `done`; 1 = alignment found.
- `shift_by`  output  SHIFT_W  rotation amount found (0 on no match).
- `out`  output  WIDTH  realigned word.

## Operation
- **States**
  - IDLE: `busy`=0.
  - SEARCH: `busy`=1.
- **IDLE → SEARCH** on a rising edge with `start`=1:
  - load working register `q` ← `in`, `in_copy` ← `in`, `pat` ← `pattern`, `dir` ← `shift_l_r`, `cnt` ← 0;
  - `match`, `shift_by` and `out` keep their previous values.
- **SEARCH**, each rising edge:
  - If `q == pat`: `match`←1, `shift_by`←`cnt`, `out`←`q`, `done`←1, go to IDLE.
  - Else if `cnt == WIDTH-1`: `match`←0, `shift_by`←0, `out`←`in_copy`, `done`←1, go to IDLE.
  - Else: rotate `q` one bit opposite to `dir`, then `cnt`←`cnt`+1.
    - `dir`=0: right rotate, {q[0], q[WIDTH-1:1]}.
    - `dir`=1: left rotate, {q[WIDTH-2:0], q[WIDTH-1]}.
- **Result semantics**
  - The smallest `k` in 0..WIDTH-1 wins, which matters for periodic patterns such as 0x00, 0xFF and 0x55.
  - `k` equals the `shift_by` the encoder applied, modulo the pattern period.
- **Start handling**
  - `start` while `busy`=1 is ignored: no restart, no queueing.
  - `start` held high in the same cycle that `done` pulses is not accepted, because the FSM is still in SEARCH at that edge. It is accepted at the next edge if still high.
- **Result hold:** `match`, `shift_by` and `out` hold until the next completed search.
- **Arithmetic:** `cnt` is SHIFT_W bits wide and never wraps; the terminal check at WIDTH-1 prevents it.

## Timing
- **Reset:** while `RS`=1, immediately and regardless of `CK`:
  - state = IDLE;
  - `busy`=0, `done`=0, `match`=0, `shift_by`=0, `out`=0;
  - `q`, `cnt`, `pat`, `in_copy` and `dir` cleared.
- **Reset mid-search:** the search aborts with no `done` pulse, and outputs go to their reset values.
- **Latency** (start accepted at edge 0):
  - a match at amount `k` raises `done` after edge k+1, so `done` is high during cycle k+1 → k+2;
  - no match raises `done` after edge WIDTH;
  - worst case is WIDTH+1 edges from accept to `done` falling.
- **Output timing**
  - `busy` rises after edge 0 and falls in the same cycle `done` rises.
  - `done` is high exactly one cycle per accepted start.
  - All outputs are registered; none are combinational from inputs.
- **Back-to-back searches:** the earliest next accept is the edge at which `done` falls.

## Test plan
- Reset during an idle period, then release → all outputs 0, `busy`=0. Reset asserted at SEARCH cnt=3 → outputs 0 immediately, no `done` afterwards.
- `in`=0x8D, `pattern`=0xB1, `shift_l_r`=0, start → `done` after edge 4, `match`=1, `shift_by`=3, `out`=0xB1.
- `in`=0x8D, `pattern`=0xB1, `shift_l_r`=1, start → `done` after edge 6, `match`=1, `shift_by`=5, `out`=0xB1.
- `in`=0xB1, `pattern`=0xB1 → `done` after edge 1, `shift_by`=0, `match`=1. Separately, `in`=0x55, `pattern`=0xAA, `shift_l_r`=0 → `shift_by`=1, the smallest amount.
- `in`=0x01, `pattern`=0x03 → `done` after edge 8, `match`=0, `shift_by`=0, `out`=0x01, `busy` low from that point.
- `start` pulsed at cnt=2 of a running search → ignored; the original result is unchanged. `start` held continuously → searches run back-to-back with exactly one `done` per search and one idle edge between them.
